audio_iir_filter: RTL

Sample-rate IIR low-pass engine that consumes the coefficient set presented by the audio filter coefficient ROM (`aflt_rate`, `acx`, `acx0..2`, `acy0..2`) and applies it to the core's stereo audio stream. The block sits between the Game Boy APU mixer output and the Analogue Pocket audio serializer. It generates its own sample tick from `aflt_rate` and runs one 3rd-order direct-form-I step per channel per tick on a six-state sequential datapath.

---
 rtl/audio_iir_filter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/audio_iir_filter.sv
// audio_iir_filter: stereo 3rd-order direct-form-I IIR engine clocked by an
// internal sample tick derived from aflt_rate. One step per tick:
// IDLE -> XSUM -> GAIN -> FB0 -> FB1 -> FB2 -> WB, both channels in parallel.
// Optional build macro: IIR_SATURATE_EN -- clamp the 16-bit output instead of
// taking the wrapped low 16 bits of acc >>> 16.
module audio_iir_filter #(
    parameter int unsigned CLK_RATE = 74_250_000,
    parameter int unsigned CX_SHIFT = 40
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        aflt_rate,
    input  logic [39:0]        acx,
    input  logic [7:0]         acx0,
    input  logic [7:0]         acx1,
    input  logic [7:0]         acx2,
    input  logic signed [23:0] acy0,
    input  logic signed [23:0] acy1,
    input  logic signed [23:0] acy2,
    input  logic               filter_en,
    input  logic signed [15:0] audio_in_l,
    input  logic signed [15:0] audio_in_r,
    output logic signed [15:0] audio_out_l,
    output logic signed [15:0] audio_out_r,
    output logic               out_valid,
    output logic               overrun
);

    typedef enum logic [2:0] {IDLE, XSUM, GAIN, FB0, FB1, FB2, WB} state_t;

    state_t state_reg, state_next;

    logic [32:0] phase_reg;
    logic [33:0] phase_sum;
    logic        tick;
    logic        latch;
    logic        hist_clr;

    logic [39:0]        acx_reg;
    logic [7:0]         acx0_reg, acx1_reg, acx2_reg;
    logic signed [23:0] acy0_reg, acy1_reg, acy2_reg;
    logic               en_reg;
    logic               overrun_reg;
    logic               out_valid_reg;

    logic signed [15:0] ch_in  [2];
    logic signed [15:0] ch_out [2];

    // Feedback term: 64-bit product of Q2.21 coefficient and 16-frac y, rescaled and truncated.
    function automatic logic signed [39:0] fb_term(input logic signed [23:0] c,
                                                   input logic signed [39:0] y);
        logic signed [63:0] ce;
        logic signed [63:0] ye;
        logic signed [63:0] p;
        ce = {{40{c[23]}}, c};
        ye = {{24{y[39]}}, y};
        p  = ce * ye;
        return 40'(p >>> 21);
    endfunction

    assign phase_sum = {1'b0, phase_reg} + {2'b00, aflt_rate};
    assign tick      = (phase_sum >= 34'(CLK_RATE));
    assign latch     = tick && (state_reg == IDLE);
    // A new coefficient set (or bypass) invalidates the stored history.
    assign hist_clr  = !filter_en ||
                       ({acx, acx0, acx1, acx2, acy0, acy1, acy2} !=
                        {acx_reg, acx0_reg, acx1_reg, acx2_reg, acy0_reg, acy1_reg, acy2_reg});

    assign ch_in[0]    = audio_in_l;
    assign ch_in[1]    = audio_in_r;
    assign audio_out_l = ch_out[0];
    assign audio_out_r = ch_out[1];
    assign out_valid   = out_valid_reg;
    assign overrun     = overrun_reg;

    // Phase accumulator: wraps at CLK_RATE, each wrap is one sample tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg <= '0;
        end else if (tick) begin
            phase_reg <= 33'(phase_sum - 34'(CLK_RATE));
        end else begin
            phase_reg <= phase_sum[32:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: wait for a tick, then walk the six datapath states.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (tick) state_next = XSUM;
            XSUM:    state_next = GAIN;
            GAIN:    state_next = FB0;
            FB0:     state_next = FB1;
            FB1:     state_next = FB2;
            FB2:     state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control: coefficient/enable latch at step start, sticky overrun, output strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acx_reg       <= '0;
            acx0_reg      <= '0;
            acx1_reg      <= '0;
            acx2_reg      <= '0;
            acy0_reg      <= '0;
            acy1_reg      <= '0;
            acy2_reg      <= '0;
            en_reg        <= 1'b0;
            overrun_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (latch) begin
                acx_reg  <= acx;
                acx0_reg <= acx0;
                acx1_reg <= acx1;
                acx2_reg <= acx2;
                acy0_reg <= acy0;
                acy1_reg <= acy1;
                acy2_reg <= acy2;
                en_reg   <= filter_en;
            end
            if (tick && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end
            out_valid_reg <= (state_reg == WB);
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic signed [15:0] x_reg, x1_reg, x2_reg, x3_reg, out_reg;
        logic signed [26:0] s_reg, s_next;
        logic signed [39:0] y1_reg, y2_reg, y3_reg, acc_reg, gain_val;
        logic signed [67:0] g_prod;
        logic signed [15:0] out_val;

        assign s_next = $signed({{11{x_reg[15]}}, x_reg})
                      + $signed({19'b0, acx0_reg}) * $signed({{11{x1_reg[15]}}, x1_reg})
                      + $signed({19'b0, acx1_reg}) * $signed({{11{x2_reg[15]}}, x2_reg})
                      + $signed({19'b0, acx2_reg}) * $signed({{11{x3_reg[15]}}, x3_reg});

        assign g_prod   = $signed({{41{s_reg[26]}}, s_reg}) * $signed({28'b0, acx_reg});
        assign gain_val = 40'(g_prod >>> (CX_SHIFT - 16));

`ifdef IIR_SATURATE_EN
        logic signed [39:0] acc_sh;
        assign acc_sh = acc_reg >>> 16;
        // Clamp the integer part of acc into the 16-bit PCM range.
        always_comb begin
            out_val = acc_sh[15:0];
            if (acc_sh > 40'sd32767) begin
                out_val = 16'sh7fff;
            end else if (acc_sh < -40'sd32768) begin
                out_val = 16'sh8000;
            end
        end
`else
        assign out_val = acc_reg[31:16];
`endif

        assign ch_out[gi] = out_reg;

        // Per-channel datapath: one arithmetic operation per FSM state.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                x_reg   <= '0;
                x1_reg  <= '0;
                x2_reg  <= '0;
                x3_reg  <= '0;
                y1_reg  <= '0;
                y2_reg  <= '0;
                y3_reg  <= '0;
                s_reg   <= '0;
                acc_reg <= '0;
                out_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (latch) begin
                            x_reg <= ch_in[gi];
                            if (hist_clr) begin
                                x1_reg <= '0;
                                x2_reg <= '0;
                                x3_reg <= '0;
                                y1_reg <= '0;
                                y2_reg <= '0;
                                y3_reg <= '0;
                            end
                        end
                    end
                    XSUM: s_reg   <= s_next;
                    GAIN: acc_reg <= gain_val;
                    FB0:  acc_reg <= acc_reg - fb_term(acy0_reg, y1_reg);
                    FB1:  acc_reg <= acc_reg - fb_term(acy1_reg, y2_reg);
                    FB2:  acc_reg <= acc_reg - fb_term(acy2_reg, y3_reg);
                    WB: begin
                        if (en_reg) begin
                            x3_reg  <= x2_reg;
                            x2_reg  <= x1_reg;
                            x1_reg  <= x_reg;
                            y3_reg  <= y2_reg;
                            y2_reg  <= y1_reg;
                            y1_reg  <= acc_reg;
                            out_reg <= out_val;
                        end else begin
                            out_reg <= x_reg;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
